// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and default thresholds for the FIFO family
package fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;
    localparam int DEF_AF_THRESH  = 124;
    localparam int DEF_AE_THRESH  = 4;

    function automatic int depth_of(input int addr_width);
        return 2 ** addr_width;
    endfunction

    // One extra MSB distinguishes a full lap from an empty one
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-bit pointer with increment and synchronous clear, exposing the RAM address bits
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int AW = DEF_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [AW-1:0] o_addr
);

    localparam int PW = ptr_width(AW);

    logic [PW-1:0] r_ptr;

    always_ff @(posedge clk)
        r_ptr <= (rst || i_clr) ? '0 : i_inc ? r_ptr + PW'(1) : r_ptr;

    assign o_addr = r_ptr[AW-1:0];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller sequencing a dual-port RAM with 1-cycle read latency
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_THRESH  = DEF_AF_THRESH,
    parameter int AE_THRESH  = DEF_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  flush,
    output logic                  ram_wena,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_renb,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int            PW      = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] L_DEPTH = PW'(depth_of(ADDR_WIDTH));
    localparam logic [PW-1:0] L_AF    = PW'(AF_THRESH);
    localparam logic [PW-1:0] L_AE    = PW'(AE_THRESH);

    logic [PW-1:0] r_count;
    logic          r_rd_valid;
    logic          r_overflow;
    logic          r_underflow;
    logic          w_full;
    logic          w_empty;
    logic          w_clr;
    logic          w_push;
    logic          w_pop;

    // Flags come only from the count register, so inputs never reach them combinationally
    always_comb begin
        w_full  = r_count == L_DEPTH;
        w_empty = r_count == '0;
        w_clr   = rst | flush;
        w_push  = wr_en & ~w_full & ~w_clr;
        w_pop   = rd_en & ~w_empty & ~w_clr;
    end

    fifo_ptr #(.AW(ADDR_WIDTH)) u_wptr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (flush),
        .i_inc  (w_push),
        .o_addr (ram_waddr)
    );

    fifo_ptr #(.AW(ADDR_WIDTH)) u_rptr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (flush),
        .i_inc  (w_pop),
        .o_addr (ram_raddr)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= (w_push && !w_pop) ? r_count + PW'(1) :
                           (w_pop && !w_push) ? r_count - PW'(1) : r_count;
            r_rd_valid  <= w_pop;
            r_overflow  <= r_overflow | (wr_en & w_full);
            r_underflow <= r_underflow | (rd_en & w_empty);
        end
    end

    assign ram_wena     = w_push;
    assign ram_renb     = w_pop;
    assign rd_valid     = r_rd_valid;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = r_count >= L_AF;
    assign almost_empty = r_count <= L_AE;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed bench for sync_fifo_ctrl with a behavioural 1-cycle-latency RAM
module tb_sync_fifo_ctrl;

    localparam int AW = 7;
    localparam int AF = 124;
    localparam int AE = 4;
    localparam int D  = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst, wr_en, rd_en, flush;
    logic          ram_wena, ram_renb, rd_valid;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [AW:0]   count;

    int n_cmp = 0;
    int n_err = 0;
    int mem [D];
    int q [$];
    int wseq = 0;
    int rdata;
    int exp_rdata;
    int exp_wa;
    int exp_ra;

    initial assert (0 <= AE && AE < AF && AF <= D)
        else $fatal(1, "param_check FAIL: AE=%0d AF=%0d DEPTH=%0d", AE, AF, D);

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .flush        (flush),
        .ram_wena     (ram_wena),
        .ram_waddr    (ram_waddr),
        .ram_renb     (ram_renb),
        .ram_raddr    (ram_raddr),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic f);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        flush = f;
        #1;
    endtask

    // RAM model plus a scoreboard of written tags in push order
    always @(posedge clk) begin
        if (rst || flush) q.delete();
        if (ram_renb) begin
            rdata <= mem[ram_raddr];
            if (q.size() > 0) exp_rdata <= q.pop_front();
            else exp_rdata <= -1;
        end
        if (ram_wena) begin
            mem[ram_waddr] <= wseq;
            q.push_back(wseq);
            wseq++;
        end
    end

    always @(negedge clk)
        if (rd_valid === 1'b1) chk("rdata", rdata, exp_rdata);

    initial begin
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; flush = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_wena", ram_wena, 0);
            chk("rst_renb", ram_renb, 0);
        end
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        chk("rst_rvld", rd_valid, 0);
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

        for (int i = 0; i < D; i++) begin
            drive(1, 0, 0);
            chk("fill_wena", ram_wena, 1);
            chk("fill_waddr", ram_waddr, i);
            if (i == AF - 1 || i == AF) chk("fill_af", almost_full, i >= AF);
            if (i == D - 1) chk("fill_notfull", full, 0);
        end
        drive(1, 0, 0);
        chk("full_count", count, D);
        chk("full_flag", full, 1);
        chk("full_af", almost_full, 1);
        chk("full_wena", ram_wena, 0);
        chk("full_ovf_pre", overflow, 0);
        drive(0, 0, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, D);

        for (int i = 0; i < D; i++) begin
            drive(0, 1, 0);
            chk("drain_renb", ram_renb, 1);
            chk("drain_raddr", ram_raddr, i);
            chk("drain_count", count, D - i);
            if (i > 0) chk("drain_rvld", rd_valid, 1);
        end
        drive(0, 1, 0);
        chk("empty_renb", ram_renb, 0);
        chk("empty_rvld", rd_valid, 1);
        chk("empty_flag", empty, 1);
        chk("empty_count", count, 0);
        chk("empty_ae", almost_empty, 1);
        chk("udf_pre", underflow, 0);
        drive(0, 0, 0);
        chk("udf_set", underflow, 1);
        chk("udf_rvld", rd_valid, 0);
        chk("ovf_sticky", overflow, 1);

        repeat (10) drive(1, 0, 0);
        for (int i = 0; i < 50; i++) begin
            drive(1, 1, 0);
            chk("conc_count", count, 10);
            chk("conc_wena", ram_wena, 1);
            chk("conc_renb", ram_renb, 1);
        end
        repeat (10) drive(0, 1, 0);
        drive(0, 0, 0);
        chk("conc_drained", count, 0);
        drive(1, 1, 0);
        chk("e_both_wena", ram_wena, 1);
        chk("e_both_renb", ram_renb, 0);
        drive(0, 0, 0);
        chk("e_both_count", count, 1);
        drive(0, 1, 0);
        drive(0, 0, 0);
        chk("e_both_drained", count, 0);

        exp_wa = 61;
        exp_ra = 61;
        for (int k = 0; k < 301; k++) begin
            drive(k < 300, k > 0, 0);
            if (k < 300) begin
                chk("wrap_waddr", ram_waddr, exp_wa);
                exp_wa = (exp_wa + 1) % D;
            end
            if (k > 0) begin
                chk("wrap_raddr", ram_raddr, exp_ra);
                exp_ra = (exp_ra + 1) % D;
            end
            chk("wrap_full", full, 0);
            chk("wrap_count", count, k > 0);
        end
        drive(0, 0, 0);
        chk("wrap_end_count", count, 0);

        repeat (61) drive(1, 0, 0);
        drive(0, 1, 0);
        drive(1, 0, 1);
        chk("flush_pre_count", count, 60);
        chk("flush_pre_rvld", rd_valid, 1);
        chk("flush_wena", ram_wena, 0);
        chk("flush_renb", ram_renb, 0);
        drive(0, 0, 0);
        chk("flush_count", count, 0);
        chk("flush_rvld", rd_valid, 0);
        chk("flush_empty", empty, 1);
        chk("flush_ae", almost_empty, 1);
        chk("flush_ovf", overflow, 0);
        chk("flush_udf", underflow, 0);
        drive(1, 0, 0);
        chk("post_waddr", ram_waddr, 0);
        drive(0, 1, 0);
        chk("post_raddr", ram_raddr, 0);
        chk("post_count", count, 1);
        drive(0, 0, 0);
        chk("post_rvld", rd_valid, 1);
        drive(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
